// File: rtl/agc_code_histogram_if.sv
// Bus between the AGC histogram block and its user: sample stream, run control
// and the bin read port. The master drives data and control; the histogram is
// the slave.
interface agc_code_histogram_if #(
  parameter int BIN_WIDTH = 24
);
  logic [39:0]          dat_i;
  logic                 start_i;
  logic                 busy_o;
  logic                 done_o;
  logic [4:0]           rd_addr_i;
  logic [BIN_WIDTH-1:0] rd_dat_o;
  logic [BIN_WIDTH+2:0] total_o;

  modport master (
    output dat_i, start_i, rd_addr_i,
    input  busy_o, done_o, rd_dat_o, total_o
  );

  modport slave (
    input  dat_i, start_i, rd_addr_i,
    output busy_o, done_o, rd_dat_o, total_o
  );
endinterface

// File: rtl/agc_code_histogram.sv
// Amplitude histogram of the AGC output: 8 lanes of 5-bit two's-complement
// codes per clock are binned (offset-binary bin index) over a fixed window of
// clocks. Stage 1 counts per-bin lane matches, stage 2 accumulates them into
// saturating bin counters. Bins are read back through a registered port.
module agc_code_histogram #(
  parameter int NSAMP         = 8,
  parameter int NBITS         = 5,
  parameter int BIN_WIDTH     = 24,
  parameter int WINDOW_CLOCKS = 32768
) (
  input logic                 clk_i,
  input logic                 rst_i,
  agc_code_histogram_if.slave bus
);

  localparam int NBINS = 1 << NBITS;
  localparam int CW    = $clog2(NSAMP + 1);
  localparam int TW    = BIN_WIDTH + 3;
  localparam int BSW   = BIN_WIDTH + 1;
  localparam int TSW   = TW + 1;
  localparam int WCW   = (WINDOW_CLOCKS > 1) ? $clog2(WINDOW_CLOCKS) : 1;
  localparam logic [WCW-1:0]   LAST_CAPTURE = WCW'(WINDOW_CLOCKS - 1);
  localparam logic [NBITS-1:0] BIN_FLIP     = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s1_valid_q, s1_valid_d;
  logic [CW-1:0]    s1_cnt_q [NBINS];
  logic [CW-1:0]    s1_cnt_d [NBINS];

  logic [BIN_WIDTH-1:0] bins_q [NBINS];
  logic [BIN_WIDTH-1:0] bins_d [NBINS];
  logic [BSW-1:0]       bin_sum [NBINS];
  logic [TW-1:0]        total_q, total_d;
  logic [TSW-1:0]       total_sum;

  logic [BIN_WIDTH-1:0] rd_dat_q, rd_dat_d;

  // Run control: start always (re)opens a window; a window closes after the
  // last capture plus one drain cycle so the final stage-2 add has landed.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    s1_valid_d = 1'b0;
    if (bus.start_i) begin
      state_d   = ACCUM;
      win_cnt_d = '0;
      busy_d    = 1'b1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          s1_valid_d = 1'b1;
          win_cnt_d  = win_cnt_q + WCW'(1);
          if (win_cnt_q == LAST_CAPTURE) begin
            state_d   = DRAIN;
            win_cnt_d = '0;
          end
        end
        DRAIN: begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Control state and its registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Stage 1 match counts: how many of the lanes fall in each bin this clock.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      s1_cnt_d[b] = '0;
      for (int l = 0; l < NSAMP; l++) begin
        if ((bus.dat_i[l*NBITS +: NBITS] ^ BIN_FLIP) == NBITS'(b)) begin
          s1_cnt_d[b] = s1_cnt_d[b] + CW'(1);
        end
      end
    end
  end

  // Stage 1 registers; the valid flag gates whether stage 2 accumulates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      for (int b = 0; b < NBINS; b++) begin
        s1_cnt_q[b] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cnt_q   <= s1_cnt_d;
    end
  end

  // One-bit-wider sums so an overflow can be detected and clamped.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      bin_sum[b] = {1'b0, bins_q[b]} + BSW'(s1_cnt_q[b]);
    end
    total_sum = {1'b0, total_q} + TSW'(NSAMP);
  end

  // Stage 2 accumulate with saturation; a start clear overrides any add.
  always_comb begin
    bins_d  = bins_q;
    total_d = total_q;
    if (bus.start_i) begin
      for (int b = 0; b < NBINS; b++) begin
        bins_d[b] = '0;
      end
      total_d = '0;
    end else if (s1_valid_q) begin
      for (int b = 0; b < NBINS; b++) begin
        bins_d[b] = bin_sum[b][BIN_WIDTH] ? '1 : bin_sum[b][BIN_WIDTH-1:0];
      end
      total_d = total_sum[TW] ? '1 : total_sum[TW-1:0];
    end
  end

  // Bin and total storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBINS; b++) begin
        bins_q[b] <= '0;
      end
      total_q <= '0;
    end else begin
      bins_q  <= bins_d;
      total_q <= total_d;
    end
  end

  // Registered read port: one cycle from address to data.
  always_comb begin
    rd_dat_d = bins_q[bus.rd_addr_i];
  end

  // Read data register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.total_o  = total_q;
  assign bus.rd_dat_o = rd_dat_q;

endmodule

// File: tb/tb_agc_code_histogram.sv
// Testbench for agc_code_histogram. Two instances: a wide one (24-bit bins,
// 16-clock window) and a narrow one (4-bit bins, 4-clock window) to reach
// saturation. Bin reads go through a scoreboard queue checked by a monitor.
module tb_agc_code_histogram;

  localparam int WA  = 16;
  localparam int BWA = 24;
  localparam int WB  = 4;
  localparam int BWB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  agc_code_histogram_if #(.BIN_WIDTH(BWA)) ifa ();
  agc_code_histogram_if #(.BIN_WIDTH(BWB)) ifb ();

  agc_code_histogram #(.NSAMP(8), .NBITS(5), .BIN_WIDTH(BWA), .WINDOW_CLOCKS(WA)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  agc_code_histogram #(.NSAMP(8), .NBITS(5), .BIN_WIDTH(BWB), .WINDOW_CLOCKS(WB)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  int checks = 0;
  int passes = 0;

  // Reference histogram of the current run, in plain counts per signed value.
  longint model_bins [32];
  longint model_total;
  longint bin_max;
  longint total_max;

  typedef struct {
    int     which;
    int     addr;
    longint exp;
  } rd_exp_t;

  rd_exp_t rd_q [$];
  logic    rd_req   = 1'b0;
  logic    rd_req_q = 1'b0;
  int      rd_which = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint busyOf(input int w);
    return w != 0 ? longint'(ifb.busy_o) : longint'(ifa.busy_o);
  endfunction

  function automatic longint doneOf(input int w);
    return w != 0 ? longint'(ifb.done_o) : longint'(ifa.done_o);
  endfunction

  function automatic longint totalOf(input int w);
    return w != 0 ? longint'(ifb.total_o) : longint'(ifa.total_o);
  endfunction

  function automatic longint rdOf(input int w);
    return w != 0 ? longint'(ifb.rd_dat_o) : longint'(ifa.rd_dat_o);
  endfunction

  task automatic setIn(input int w, input logic [39:0] d, input logic s);
    if (w != 0) begin
      ifb.dat_i   = d;
      ifb.start_i = s;
    end else begin
      ifa.dat_i   = d;
      ifa.start_i = s;
    end
  endtask

  function automatic void modelClear(input int w);
    for (int b = 0; b < 32; b++) model_bins[b] = 0;
    model_total = 0;
    bin_max   = (longint'(1) << (w != 0 ? BWB : BWA)) - 1;
    total_max = (longint'(1) << ((w != 0 ? BWB : BWA) + 3)) - 1;
  endfunction

  // Each lane is a signed sample -16..15; its bin is simply value + 16.
  function automatic void modelCapture(input logic [39:0] v);
    int s;
    for (int l = 0; l < 8; l++) begin
      s = int'($signed(v[5*l +: 5]));
      if (model_bins[s + 16] < bin_max) model_bins[s + 16]++;
      if (model_total < total_max) model_total++;
    end
  endfunction

  // mode 0: all zero, 1: lane i = i-4, 2: random, 3: all -16
  function automatic logic [39:0] genData(input int mode);
    logic [39:0] d;
    logic [63:0] r;
    d = '0;
    case (mode)
      1: for (int l = 0; l < 8; l++) d[5*l +: 5] = 5'(l - 4);
      2: begin
        r = {$urandom(), $urandom()};
        d = r[39:0];
      end
      3: for (int l = 0; l < 8; l++) d[5*l +: 5] = 5'h10;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Runs one window; optionally restarts on the completion edge.
  task automatic applyStimulus(input int w, input int win, input int mode,
                               input bit issue_start, input bit end_with_start);
    logic [39:0] v;
    logic [63:0] r;
    int busy_cycles;
    if (issue_start) begin
      modelClear(w);
      setIn(w, genData(2), 1'b1);
      tick();
      checkOutput("busy_after_start", busyOf(w), 1);
      checkOutput("done_after_start", doneOf(w), 0);
      checkOutput("total_after_start", totalOf(w), 0);
    end
    busy_cycles = 1;
    for (int i = 0; i < win; i++) begin
      v = genData(mode);
      modelCapture(v);
      setIn(w, v, 1'b0);
      tick();
      if (busyOf(w) != 0) busy_cycles++;
      checkOutput("done_low_in_window", doneOf(w), 0);
    end
    r = {$urandom(), $urandom()};
    if (end_with_start) begin
      setIn(w, r[39:0], 1'b1);
      tick();
      checkOutput("restart_at_end_done", doneOf(w), 0);
      checkOutput("restart_at_end_busy", busyOf(w), 1);
      checkOutput("restart_at_end_total", totalOf(w), 0);
      modelClear(w);
    end else begin
      setIn(w, r[39:0], 1'b0);
      tick();
      checkOutput("done_at_end", doneOf(w), 1);
      checkOutput("busy_at_end", busyOf(w), 0);
      checkOutput("total_at_end", totalOf(w), model_total);
      checkOutput("busy_cycle_count", busy_cycles, win + 1);
    end
  endtask

  // Sweeps all 32 addresses on consecutive clocks, queueing expected values.
  task automatic readSweep(input int w);
    rd_exp_t e;
    rd_which = w;
    rd_req   = 1'b1;
    for (int a = 0; a < 32; a++) begin
      ifa.rd_addr_i = 5'(a);
      ifb.rd_addr_i = 5'(a);
      e.which = w;
      e.addr  = a;
      e.exp   = model_bins[a];
      rd_q.push_back(e);
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  // Mirrors the one-cycle read latency so the monitor knows data is due.
  always @(posedge clk) begin
    rd_req_q <= rd_req;
  end

  // Monitor: pops an expectation for every read result the DUT presents.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (rd_req_q) begin
        if (rd_q.size() == 0) begin
          checkOutput("rd_unexpected", rdOf(rd_which), -1);
        end else begin
          e = rd_q.pop_front();
          checkOutput($sformatf("rd_dat[%0d] dut%0d", e.addr, e.which), rdOf(e.which), e.exp);
        end
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [39:0] v;
    rst = 1'b1;
    ifa.dat_i = '0; ifa.start_i = 1'b0; ifa.rd_addr_i = '0;
    ifb.dat_i = '0; ifb.start_i = 1'b0; ifb.rd_addr_i = '0;
    #2;
    checkOutput("reset_busy", busyOf(0), 0);
    checkOutput("reset_done", doneOf(0), 0);
    checkOutput("reset_total", totalOf(0), 0);
    checkOutput("reset_rd", rdOf(0), 0);
    checkOutput("reset_busy_b", busyOf(1), 0);
    #10;
    rst = 1'b0;
    tick();
    tick();
    checkOutput("idle_busy", busyOf(0), 0);

    $display("[TB] all-zero window on wide instance");
    applyStimulus(0, WA, 0, 1'b1, 1'b0);
    readSweep(0);

    $display("[TB] lane ramp -4..3 on narrow instance");
    applyStimulus(1, WB, 1, 1'b1, 1'b0);
    readSweep(1);
    setIn(1, {8{5'h0F}}, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("ignored_total", totalOf(1), model_total);
    readSweep(1);

    $display("[TB] random windows on wide instance");
    for (int n = 0; n < 3; n++) begin
      applyStimulus(0, WA, 2, 1'b1, 1'b0);
      readSweep(0);
    end

    $display("[TB] restart five clocks into a window");
    setIn(0, genData(2), 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      setIn(0, genData(2), 1'b0);
      tick();
      checkOutput("restart_done_low", doneOf(0), 0);
    end
    applyStimulus(0, WA, 2, 1'b1, 1'b0);
    readSweep(0);

    $display("[TB] restart on the completion edge");
    applyStimulus(0, WA, 2, 1'b1, 1'b1);
    applyStimulus(0, WA, 2, 1'b0, 1'b0);
    readSweep(0);

    $display("[TB] saturation on narrow instance");
    applyStimulus(1, WB, 3, 1'b1, 1'b0);
    readSweep(1);

    $display("[TB] asynchronous reset mid-window");
    ifa.rd_addr_i = 5'd16;
    setIn(0, genData(2), 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      v = {8{5'h00}};
      setIn(0, v, 1'b0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_busy", busyOf(0), 0);
    checkOutput("async_done", doneOf(0), 0);
    checkOutput("async_total", totalOf(0), 0);
    checkOutput("async_rd", rdOf(0), 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setIn(0, genData(2), 1'b0);
      tick();
    end
    checkOutput("post_reset_busy", busyOf(0), 0);
    checkOutput("post_reset_done", doneOf(0), 0);
    checkOutput("post_reset_total", totalOf(0), 0);
    modelClear(0);
    readSweep(0);

    checkOutput("scoreboard_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
